mitll_jtl_sched: RTL and testbench
==================================

# mitll_jtl_sched

Clocked round-robin scheduler that shares one JTL drive line among `N_REQ` pulse sources. Each source's pulses are counted, queued and re-emitted on the shared line no closer than `MIN_GAP` clock cycles apart, so the downstream JTL's hold constraint of 3.4 ps between input transitions is never violated. The block sits between SFQ pulse producers (splitter/merger outputs) and a single `mitll_jtl` chain. Pulses use toggle encoding on every line: each transition, rising or falling, is one pulse.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `CNT_W`, default 3: width of each pending-pulse counter; saturates at 2^CNT_W-1.
- `MIN_GAP`, default 2: minimum clock cycles between successive output toggles (≥1).
- `clk` in 1: single clock. All state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_in` in N_REQ: toggle-encoded pulse inputs. Must be held at 0 while `rst_n`=0.
- `out` out 1: toggle-encoded shared output. Drives the JTL input.
- `grant_id` out $clog2(N_REQ): index of the requester served by the most recent toggle.
- `busy` out 1: high while any pulse is pending or a gap is running.
- `overflow` out N_REQ: sticky per-requester flag, set when a pulse was dropped.
- `pulse_count` out 16: number of emitted pulses. Exists only with `JTL_SCHED_STATS_EN`.

## Operation
- Reset values (asynchronous, while `rst_n`=0): `out`=0, `grant_id`=0, `busy`=0, `overflow`=0, `pulse_count`=0, all `pend[i]`=0, internal `req_q`=0, `ptr`=0, state=IDLE, `gap_cnt`=0.
- Event detection: on each edge `req_q<=req_in`. `ev[i]=req_in[i]^req_q[i]` is evaluated at that edge. At most one pulse per requester per cycle is counted.
- Pending counters: `ev[i]` increments `pend[i]`.
  - If `pend[i]` is saturated and not granted this edge, the event is dropped and `overflow[i]` is set.
  - Event and grant for the same i on the same edge: `pend[i]` is unchanged and `overflow` is not set.
- FSM, two states:
  - IDLE: if any `pend[i]`≠0 before the edge, grant the first nonzero i searching from `ptr` upward with wrap. On a grant:
    - `out` toggles.
    - `grant_id<=i`.
    - `pend[i]` decrements.
    - `ptr<=(i+1) mod N_REQ`.
    - `pulse_count` increments, wrapping at 2^16.
    - If MIN_GAP>1: go to GAP with `gap_cnt<=MIN_GAP-2`. Otherwise stay in IDLE.
    - With no pending pulses, all outputs hold.
  - GAP: no grant is made. If `gap_cnt`=0 go to IDLE; else `gap_cnt` decrements. Events are still counted.
- `busy` is registered: it is high after an edge if the next state is GAP, or if any `pend` is nonzero.
- `overflow` bits clear only on reset.

## Timing
- Latency: a `req_in` transition present before edge k updates `pend` at edge k. The earliest corresponding `out` toggle is at edge k+1.
- Spacing: successive `out` toggles are exactly MIN_GAP edges apart while work is pending, and never fewer.
- Throughput: one pulse per MIN_GAP cycles, shared among all requesters.
- Fairness: with all requesters continuously pending, each requester gets exactly 1 grant per N_REQ grants.
- Reset asserted mid-gap or mid-queue clears everything immediately. No `out` toggle occurs on the deassertion edge.
- `out` is a flop output with no combinational path from `req_in`.

## Configuration
- `JTL_SCHED_STATS_EN`:
  - Defined: the 16-bit `pulse_count` register and port are present.
  - Undefined: the port and register are omitted, and the behaviour of all other outputs is identical.

## Test plan
- Single pulse: reset, then `req_in[2]` goes 0→1 before edge 5. Required: `out` toggles at edge 6, `grant_id`=2, `busy` is high after edge 5 and low after edge 7 (MIN_GAP=2).
- Simultaneous: all 4 inputs toggle before edge 3. Required: grants at edges 4, 6, 8, 10 in order 0, 1, 2, 3; `out` toggles 4 times; `pulse_count`=4.
- Round-robin wrap: after a grant to 3, requesters 1 and 3 are pending. Required: next grant goes to 1, then 3.
- Saturation: CNT_W=3, `req_in[0]` toggles on 10 consecutive edges, with MIN_GAP=4 and another requester pending. Required: `overflow[0]`=1 and exactly the counted pulses (≤7 queued plus grants taken) are emitted; other `overflow` bits stay 0.
- Reset mid-gap: 3 pulses pending, `rst_n` dropped between edges. Required: all outputs are 0 immediately, and no toggles occur after release.
- MIN_GAP=1: two requesters each pending 2. Required: toggles on 4 consecutive edges, alternating ids 0, 1, 0, 1.

Source files
------------

// File: rtl/mitll_jtl_sched.sv
// rtl/mitll_jtl_sched.sv - round-robin pulse scheduler sharing one JTL drive line; optional stats via JTL_SCHED_STATS_EN
module mitll_jtl_sched #(
    parameter int N_REQ   = 4,
    parameter int CNT_W   = 3,
    parameter int MIN_GAP = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_in,
    output logic                     out,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
`ifdef JTL_SCHED_STATS_EN
    output logic [N_REQ-1:0]         overflow,
    output logic [15:0]              pulse_count
`else
    output logic [N_REQ-1:0]         overflow
`endif
);

    localparam int ID_W     = $clog2(N_REQ);
    localparam int GAP_W    = (MIN_GAP > 2) ? $clog2(MIN_GAP - 1) : 1;
    localparam int GAP_INIT = (MIN_GAP > 1) ? MIN_GAP - 2 : 0;

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } state_t;

    state_t                      state, state_d;
    logic [N_REQ-1:0]            req_q;
    logic [N_REQ-1:0]            ev;
    logic [N_REQ-1:0]            dec;
    logic [N_REQ-1:0][CNT_W-1:0] pend, pend_d;
    logic [ID_W-1:0]             ptr, ptr_d;
    logic [ID_W-1:0]             grant_idx, grant_id_d;
    logic                        grant_vld;
    logic [GAP_W-1:0]            gap_cnt, gap_cnt_d;
    logic                        out_d, busy_d;
    logic [N_REQ-1:0]            overflow_d;

    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_REQ) sum = sum - N_REQ;
        return ID_W'(sum);
    endfunction

    assign ev = req_in ^ req_q;

    // Walk offsets high to low so the nearest pending requester after ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (state == IDLE) begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                if (pend[rr_idx(ptr, k)] != '0) begin
                    grant_vld = 1'b1;
                    grant_idx = rr_idx(ptr, k);
                end
            end
        end
    end

    always_comb begin
        dec = '0;
        if (grant_vld) dec[grant_idx] = 1'b1;
    end

    always_comb begin
        state_d    = state;
        gap_cnt_d  = gap_cnt;
        out_d      = out;
        grant_id_d = grant_id;
        ptr_d      = ptr;
        pend_d     = pend;
        overflow_d = overflow;

        // An event and a grant on the same counter cancel out.
        for (int i = 0; i < N_REQ; i++) begin
            if (ev[i] && !dec[i]) begin
                if (pend[i] == '1) overflow_d[i] = 1'b1;
                else               pend_d[i]     = pend[i] + 1'b1;
            end else if (dec[i] && !ev[i]) begin
                pend_d[i] = pend[i] - 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (grant_vld) begin
                    out_d      = ~out;
                    grant_id_d = grant_idx;
                    ptr_d      = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    if (MIN_GAP > 1) begin
                        state_d   = GAP;
                        gap_cnt_d = GAP_W'(GAP_INIT);
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_d   = IDLE;
                else               gap_cnt_d = gap_cnt - 1'b1;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == GAP) || (pend_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            out      <= 1'b0;
            grant_id <= '0;
            ptr      <= '0;
            pend     <= '0;
            req_q    <= '0;
            overflow <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            gap_cnt  <= gap_cnt_d;
            out      <= out_d;
            grant_id <= grant_id_d;
            ptr      <= ptr_d;
            pend     <= pend_d;
            req_q    <= req_in;
            overflow <= overflow_d;
            busy     <= busy_d;
        end
    end

`ifdef JTL_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         pulse_count <= '0;
        else if (grant_vld) pulse_count <= pulse_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_mitll_jtl_sched.sv
// tb/tb_mitll_jtl_sched.sv - directed self-checking bench for mitll_jtl_sched
module tb_mitll_jtl_sched;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, rst_c;
    logic [3:0] req_a, req_b, req_c;
    logic       out_a, out_b, out_c;
    logic [1:0] gid_a, gid_b, gid_c;
    logic       busy_a, busy_b, busy_c;
    logic [3:0] ovf_a, ovf_b, ovf_c;
`ifdef JTL_SCHED_STATS_EN
    logic [15:0] pc_a, pc_b, pc_c;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // a: MIN_GAP=2, b: MIN_GAP=4, c: MIN_GAP=1
    mitll_jtl_sched #(.N_REQ(4), .CNT_W(3), .MIN_GAP(2)) dut_a (
        .clk(clk), .rst_n(rst_a), .req_in(req_a), .out(out_a), .grant_id(gid_a),
        .busy(busy_a),
`ifdef JTL_SCHED_STATS_EN
        .overflow(ovf_a), .pulse_count(pc_a)
`else
        .overflow(ovf_a)
`endif
    );

    mitll_jtl_sched #(.N_REQ(4), .CNT_W(3), .MIN_GAP(4)) dut_b (
        .clk(clk), .rst_n(rst_b), .req_in(req_b), .out(out_b), .grant_id(gid_b),
        .busy(busy_b),
`ifdef JTL_SCHED_STATS_EN
        .overflow(ovf_b), .pulse_count(pc_b)
`else
        .overflow(ovf_b)
`endif
    );

    mitll_jtl_sched #(.N_REQ(4), .CNT_W(3), .MIN_GAP(1)) dut_c (
        .clk(clk), .rst_n(rst_c), .req_in(req_c), .out(out_c), .grant_id(gid_c),
        .busy(busy_c),
`ifdef JTL_SCHED_STATS_EN
        .overflow(ovf_c), .pulse_count(pc_c)
`else
        .overflow(ovf_c)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        req_a = '0;   req_b = '0;   req_c = '0;
        tick();
        tick();
        #3;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        tick();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        #2;
        n_checks++;
        if ({out_a, gid_a, busy_a, ovf_a} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_a: got %b expected 00000000", {out_a, gid_a, busy_a, ovf_a});
        end
        n_checks++;
        if ({out_b, gid_b, busy_b, ovf_b, out_c, gid_c, busy_c, ovf_c} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_bc: got %h expected 0000", {out_b, gid_b, busy_b, ovf_b, out_c, gid_c, busy_c, ovf_c});
        end
    endtask

    task automatic test_single_pulse;
        do_reset();
        tick(); tick(); tick();
        req_a[2] = 1'b1;
        tick();
        n_checks++;
        if (out_a !== 1'b0 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL single_queued: out=%b busy=%b expected out=0 busy=1", out_a, busy_a);
        end
        tick();
        n_checks++;
        if (out_a !== 1'b1 || gid_a !== 2'd2 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: out=%b id=%0d busy=%b expected 1 2 1", out_a, gid_a, busy_a);
        end
        tick();
        n_checks++;
        if (out_a !== 1'b1 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: out=%b busy=%b expected out=1 busy=0", out_a, busy_a);
        end
    endtask

    task automatic test_simultaneous;
        logic exp_out;
        logic [1:0] exp_id;
        do_reset();
        exp_out = 1'b0;
        exp_id  = 2'd0;
        req_a = 4'hF;
        for (int e = 1; e <= 9; e++) begin
            tick();
            if (e == 2 || e == 4 || e == 6 || e == 8) begin
                exp_out = ~exp_out;
                exp_id  = 2'((e - 2) / 2);
            end
            n_checks++;
            if (out_a !== exp_out || gid_a !== exp_id || busy_a !== (e <= 8)) begin
                n_fail++;
                $display("FAIL simul_e%0d: out=%b id=%0d busy=%b expected %b %0d %b",
                         e, out_a, gid_a, busy_a, exp_out, exp_id, (e <= 8));
            end
        end
`ifdef JTL_SCHED_STATS_EN
        n_checks++;
        if (pc_a !== 16'd4) begin
            n_fail++;
            $display("FAIL simul_count: got %0d expected 4", pc_a);
        end
`endif
    endtask

    task automatic test_rr_wrap;
        do_reset();
        req_a = 4'b1000;
        tick();
        tick();
        n_checks++;
        if (out_a !== 1'b1 || gid_a !== 2'd3) begin
            n_fail++;
            $display("FAIL rr_first: out=%b id=%0d expected 1 3", out_a, gid_a);
        end
        req_a = 4'b0010;
        tick();
        tick();
        n_checks++;
        if (out_a !== 1'b0 || gid_a !== 2'd1) begin
            n_fail++;
            $display("FAIL rr_wrap1: out=%b id=%0d expected 0 1", out_a, gid_a);
        end
        tick();
        n_checks++;
        if (out_a !== 1'b0 || gid_a !== 2'd1) begin
            n_fail++;
            $display("FAIL rr_gap: out=%b id=%0d expected 0 1", out_a, gid_a);
        end
        tick();
        n_checks++;
        if (out_a !== 1'b1 || gid_a !== 2'd3) begin
            n_fail++;
            $display("FAIL rr_wrap3: out=%b id=%0d expected 1 3", out_a, gid_a);
        end
    endtask

    task automatic test_saturation;
        logic exp_out;
        logic [1:0] exp_id;
        int toggles;
        do_reset();
        exp_out = 1'b0;
        exp_id  = 2'd0;
        toggles = 0;
        for (int e = 1; e <= 45; e++) begin
            if (e <= 10) req_b[0] = ~req_b[0];
            if (e == 1)  req_b[1] = 1'b1;
            tick();
            if (e >= 2 && e <= 38 && ((e - 2) % 4) == 0) begin
                exp_out = ~exp_out;
                exp_id  = (e == 6) ? 2'd1 : 2'd0;
                toggles++;
            end
            n_checks++;
            if (out_b !== exp_out || gid_b !== exp_id || ovf_b !== ((e >= 9) ? 4'b0001 : 4'b0000)) begin
                n_fail++;
                $display("FAIL sat_e%0d: out=%b id=%0d ovf=%b expected %b %0d %b",
                         e, out_b, gid_b, ovf_b, exp_out, exp_id, ((e >= 9) ? 4'b0001 : 4'b0000));
            end
        end
        n_checks++;
        if (busy_b !== 1'b0 || toggles != 10) begin
            n_fail++;
            $display("FAIL sat_end: busy=%b toggles=%0d expected 0 10", busy_b, toggles);
        end
    endtask

    task automatic test_reset_mid_gap;
        do_reset();
        req_a = 4'b0111;
        tick();
        tick();
        n_checks++;
        if (out_a !== 1'b1 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: out=%b busy=%b expected 1 1", out_a, busy_a);
        end
        #3;
        rst_a = 1'b0;
        req_a = 4'b0000;
        #1;
        n_checks++;
        if ({out_a, gid_a, busy_a, ovf_a} !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_async: got %b expected 00000000", {out_a, gid_a, busy_a, ovf_a});
        end
        tick();
        #3;
        rst_a = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            n_checks++;
            if (out_a !== 1'b0 || busy_a !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_after_e%0d: out=%b busy=%b expected 0 0", e, out_a, busy_a);
            end
        end
    endtask

    task automatic test_min_gap_one;
        logic exp_out;
        do_reset();
        exp_out = 1'b0;
        req_c = 4'b0011;
        tick();
        req_c = 4'b0000;
        for (int e = 2; e <= 6; e++) begin
            tick();
            if (e <= 5) exp_out = ~exp_out;
            n_checks++;
            if (out_c !== exp_out || (e <= 5 && gid_c !== 2'((e - 2) % 2)) || busy_c !== (e <= 4)) begin
                n_fail++;
                $display("FAIL gap1_e%0d: out=%b id=%0d busy=%b expected %b %0d %b",
                         e, out_c, gid_c, busy_c, exp_out, (e - 2) % 2, (e <= 4));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_simultaneous();
        test_rr_wrap();
        test_saturation();
        test_reset_mid_gap();
        test_min_gap_one();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
